consumer: RTL and testbench

Sink stage that sits directly downstream of `generator`. It terminates that block's valid/ready stream, applies a programmable back-pressure pattern on `ready_o`, and counts accepted beats. Optionally, it checks that the received data is an incrementing sequence. Used in TLM/RTL co-simulation experiments to stress the generator's register slice under stall conditions.

---
 rtl/consumer.sv | 174 +++++++++++++++++
 tb/tb_consumer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/consumer.sv
// -----------------------------------------------------------------------------
// consumer
//
// Sink stage that terminates a valid/ready stream from an upstream generator.
// It drives a programmable back-pressure pattern on ready_o, counts accepted
// beats, records the last accepted data word and, optionally, checks that the
// received data forms an incrementing sequence.
//
// Configuration macro:
//   CONSUMER_SEQ_CHECK_EN - when defined, the incrementing-sequence checker is
//                           built in; when undefined, err_o / err_count_o are
//                           tied to zero and no checker state exists.
//
// Parameters:
//   DW     data width (must match the upstream generator)
//   DELAY  cycles ready_o stays low after each accepted beat (0 = always ready)
//   CW     width of the beat and error counters
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous, active-high reset
//   valid_i      in   upstream data valid
//   data_i       in   upstream data
//   ready_o      out  registered ready to upstream
//   rx_count_o   out  number of accepted beats (wraps)
//   last_data_o  out  data of the most recent accepted beat
//   err_o        out  sticky sequence-error flag
//   err_count_o  out  number of mismatching beats (saturates)
// -----------------------------------------------------------------------------
module consumer #(
    parameter int DW    = 16,
    parameter int DELAY = 0,
    parameter int CW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    output logic [CW-1:0] rx_count_o,
    output logic [DW-1:0] last_data_o,
    output logic          err_o,
    output logic [CW-1:0] err_count_o
);

    // Stall counter must hold DELAY-1; keep at least one bit so DELAY=0 is legal.
    localparam int SW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

    typedef enum logic [1:0] {
        S_INIT,
        S_ACCEPT,
        S_STALL
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic            ready_q, ready_d;
    logic [CW-1:0]   rx_q, rx_d;
    logic [DW-1:0]   last_q, last_d;
    logic            beat;

    // ready_q is a flop, so the handshake never depends combinationally on valid_i.
    assign beat = valid_i && ready_q;

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        stall_d = stall_q;
        rx_d    = rx_q;
        last_d  = last_q;

        unique case (state_q)
            S_INIT: begin
                state_d = S_ACCEPT;
            end
            S_ACCEPT: begin
                if (beat && (DELAY > 0)) begin
                    stall_d = SW'((DELAY > 0) ? DELAY - 1 : 0);
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                if (stall_q == '0) begin
                    state_d = S_ACCEPT;
                end else begin
                    stall_d = stall_q - 1'b1;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        if (beat) begin
            rx_d   = rx_q + 1'b1;
            last_d = data_i;
        end
    end

    // Registering the decoded next state keeps ready_o a pure flop output.
    assign ready_d = (state_d == S_ACCEPT);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample their inputs from the same edge, independent of statement order.
        if (rst) begin
            state_q <= S_INIT;
            stall_q <= '0;
            ready_q <= 1'b0;
            rx_q    <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            ready_q <= ready_d;
            rx_q    <= rx_d;
            last_q  <= last_d;
        end
    end

    assign ready_o     = ready_q;
    assign rx_count_o  = rx_q;
    assign last_data_o = last_q;

    // -------------------------------------------------------------------------
    // Optional incrementing-sequence checker
    // -------------------------------------------------------------------------
`ifdef CONSUMER_SEQ_CHECK_EN
    logic [DW-1:0] exp_q, exp_d;
    logic          err_q, err_d;
    logic [CW-1:0] errc_q, errc_d;

    always_comb begin
        exp_d  = exp_q;
        err_d  = err_q;
        errc_d = errc_q;
        if (beat) begin
            if (data_i == exp_q) begin
                exp_d = exp_q + 1'b1;
            end else begin
                err_d = 1'b1;
                if (errc_q != '1) begin
                    errc_d = errc_q + 1'b1;
                end
                // Resynchronise on the received value so one bad word costs one error.
                exp_d = data_i + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q  <= '0;
            err_q  <= 1'b0;
            errc_q <= '0;
        end else begin
            exp_q  <= exp_d;
            err_q  <= err_d;
            errc_q <= errc_d;
        end
    end

    assign err_o       = err_q;
    assign err_count_o = errc_q;
`else
    assign err_o       = 1'b0;
    assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_consumer.sv
// -----------------------------------------------------------------------------
// tb_consumer
//
// Two consumer instances with independent streams:
//   u0: DELAY=0, CW=4  (narrow counters exercise beat wrap and error saturation)
//   u1: DELAY=3, CW=32 (back-pressure pattern and reset in the middle of a stall)
// Each stream draws words from a per-instance source queue; a reference model
// predicts the post-edge outputs every cycle and pushes them to a scoreboard,
// and a monitor pops and compares one entry per cycle after the rising edge.
// -----------------------------------------------------------------------------
module tb_consumer;

    localparam int DW = 16;
    localparam int D0 = 0;
    localparam int D1 = 3;

    typedef struct {
        bit      rdy;
        longint  rx;
        longint  last;
        bit      err;
        longint  errc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic          vld [2];
    logic [DW-1:0] dat [2];

    logic          rdy0, rdy1, err0, err1;
    logic [3:0]    rx0, errc0;
    logic [31:0]   rx1, errc1;
    logic [DW-1:0] last0, last1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (per instance)
    int      dly   [2] = '{D0, D1};
    longint  mask  [2] = '{64'hF, 64'hFFFF_FFFF};
    int      m_wait[2];
    longint  m_rx  [2];
    longint  m_last[2];
    bit      m_err [2];
    longint  m_errc[2];
    longint  m_exp [2];
    bit      tog = 1'b0;

    int   src [2][$];
    exp_t sb  [2][$];

    always #5 clk = ~clk;

    consumer #(.DW(DW), .DELAY(D0), .CW(4)) u0 (
        .clk(clk), .rst(rst), .valid_i(vld[0]), .data_i(dat[0]),
        .ready_o(rdy0), .rx_count_o(rx0), .last_data_o(last0),
        .err_o(err0), .err_count_o(errc0)
    );

    consumer #(.DW(DW), .DELAY(D1), .CW(32)) u1 (
        .clk(clk), .rst(rst), .valid_i(vld[1]), .data_i(dat[1]),
        .ready_o(rdy1), .rx_count_o(rx1), .last_data_o(last1),
        .err_o(err1), .err_count_o(errc1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge and predict the outputs
    // that must be visible after the next rising edge.
    task automatic step(input bit r, input int vprob);
        @(negedge clk);
        rst = r;
        for (int k = 0; k < 2; k++) begin
            bit v;
            bit beat;
            int d;
            v = (vprob < 0) ? tog : ($urandom_range(0, 99) < vprob);
            v = v && (src[k].size() > 0);
            d = v ? src[k][0] : int'($urandom_range(0, 65535));
            vld[k] = v;
            dat[k] = DW'(d);
            beat = v && (m_wait[k] == 0) && !r;
            if (r) begin
                m_wait[k] = 1;
                m_rx[k]   = 0;
                m_last[k] = 0;
                m_err[k]  = 0;
                m_errc[k] = 0;
                m_exp[k]  = 0;
            end else if (beat) begin
                void'(src[k].pop_front());
                m_rx[k]   = (m_rx[k] + 1) & mask[k];
                m_last[k] = d;
`ifdef CONSUMER_SEQ_CHECK_EN
                if (d == m_exp[k]) begin
                    m_exp[k] = (m_exp[k] + 1) % 65536;
                end else begin
                    m_err[k] = 1;
                    if (m_errc[k] != mask[k]) m_errc[k]++;
                    m_exp[k] = (d + 1) % 65536;
                end
`endif
                m_wait[k] = dly[k];
            end else if (m_wait[k] > 0) begin
                m_wait[k]--;
            end
            sb[k].push_back('{rdy: (m_wait[k] == 0), rx: m_rx[k], last: m_last[k],
                              err: m_err[k], errc: m_errc[k]});
        end
        tog = ~tog;
    endtask

    task automatic push_both(input int v);
        src[0].push_back(v);
        src[1].push_back(v);
    endtask

    // Run until both source queues are consumed, within a cycle budget.
    task automatic drain(input int vprob, input string tag);
        int n = 0;
        while ((src[0].size() > 0 || src[1].size() > 0) && n < 5000) begin
            step(1'b0, vprob);
            n++;
        end
        if (src[0].size() > 0 || src[1].size() > 0) begin
            n_bad++;
            $display("FAIL %s_timeout: %0d/%0d words left, required 0", tag, src[0].size(), src[1].size());
            src[0].delete();
            src[1].delete();
        end
    endtask

    // Monitor: one scoreboard entry per instance per cycle.
    always @(posedge clk) begin
        #1;
        if (sb[0].size() > 0) begin
            exp_t e;
            e = sb[0].pop_front();
            check("u0_ready", 64'(rdy0), 64'(e.rdy));
            check("u0_rx_count", 64'(rx0), e.rx);
            check("u0_last_data", 64'(last0), e.last);
            check("u0_err", 64'(err0), 64'(e.err));
            check("u0_err_count", 64'(errc0), e.errc);
        end
        if (sb[1].size() > 0) begin
            exp_t e;
            e = sb[1].pop_front();
            check("u1_ready", 64'(rdy1), 64'(e.rdy));
            check("u1_rx_count", 64'(rx1), e.rx);
            check("u1_last_data", 64'(last1), e.last);
            check("u1_err", 64'(err1), 64'(e.err));
            check("u1_err_count", 64'(errc1), e.errc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        int n;
        vld[0] = 1'b0; vld[1] = 1'b0;
        dat[0] = '0;   dat[1] = '0;

        // Reset, then an in-order burst 0..9 under continuous valid.
        step(1'b1, 0);
        step(1'b1, 0);
        for (int i = 0; i < 10; i++) push_both(i);
        drain(100, "burst");

        // Longer continuous-valid run: ready pattern 1,0,0,0 on u1.
        for (int i = 10; i < 30; i++) push_both(i);
        drain(100, "cont");

        // Skipped values: one error for the jump, none for the following words.
        push_both(30); push_both(31); push_both(32);
        push_both(37); push_both(38); push_both(39);
        drain(100, "skip");

        // Alternating valid; garbage data on invalid cycles must be ignored.
        for (int i = 40; i < 52; i++) push_both(i);
        drain(-1, "toggle");

        // Data wrap at 2^DW-1 -> 0.
        for (int i = 65533; i < 65536; i++) push_both(i);
        for (int i = 0; i < 3; i++) push_both(i);
        drain(100, "wrap");

        // Randomised traffic with occasional jumps (drives u0 error saturation).
        nxt = 3;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) nxt = int'($urandom_range(0, 65535));
            push_both(nxt);
            nxt = (nxt + 1) % 65536;
        end
        drain(70, "random");

        // Reset asserted during u1's second stall cycle.
        for (int i = 100; i < 110; i++) push_both(i);
        step(1'b0, 100);
        n = 0;
        while (m_wait[1] != 2 && n < 50) begin
            step(1'b0, 100);
            n++;
        end
        if (m_wait[1] != 2) begin
            n_bad++;
            $display("FAIL stall_reach: wait %0d, required 2", m_wait[1]);
        end
        step(1'b1, 100);
        src[0].delete();
        src[1].delete();

        // Normal operation resumes with expected sequence starting at 0.
        for (int i = 0; i < 6; i++) push_both(i);
        drain(100, "resume");
        step(1'b0, 0);
        step(1'b0, 0);

        @(posedge clk);
        #2;
        if (sb[0].size() != 0 || sb[1].size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0", sb[0].size(), sb[1].size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
